mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-to-one arbiter sharing one single-port unified memory between the core's instruction-fetch port and its load/store port. It sits between the core and the memory and serialises accesses with a request/acknowledge handshake. Data accesses have priority, with a bounded streak so fetch cannot starve. A timeout guarantees that every accepted request completes.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- DM_STREAK_MAX, 4, max consecutive data grants while a fetch is pending (≥1)
- TIMEOUT, 64, cycles in BUSY without i_mem_ack before abort (≥2)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_if_req  in  1  fetch request, held until o_if_ack
- i_if_addr  in  ADDR_W  fetch address
- o_if_ack  out  1  one-cycle completion pulse
- o_if_rdata  out  DATA_W  fetch data, valid with o_if_ack
- i_dm_req  in  1  data request, held until o_dm_ack
- i_dm_we  in  1  1 = write
- i_dm_be  in  DATA_W/8  byte enables
- i_dm_addr  in  ADDR_W  data address
- i_dm_wdata  in  DATA_W  write data
- o_dm_ack  out  1  one-cycle completion pulse
- o_dm_rdata  out  DATA_W  read data, valid with o_dm_ack (0 for writes)
- o_err  out  1  high with the ack of an aborted (timed-out) transaction
- o_mem_req  out  1  memory request, held until i_mem_ack or timeout
- o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered command, stable while o_mem_req
- i_mem_ack  in  1  memory completion pulse
- i_mem_rdata  in  DATA_W  memory read data, valid with i_mem_ack

## Operation
- FSM states: IDLE, BUSY, RESP. Owner register: IF or DM.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner:
    - DM wins if i_dm_req and (not i_if_req or streak < DM_STREAK_MAX).
    - Otherwise IF wins.
  - Latch the winner's command into o_mem_*. Fetch commands force we=0 and be=all-ones; wdata=0.
  - Go to BUSY.
- Streak counter:
  - Increments when DM wins while i_if_req is high; saturates at DM_STREAK_MAX.
  - Clears when IF wins.
  - Unchanged when DM wins with no fetch pending.
- BUSY:
  - o_mem_req=1; timeout counter increments each cycle.
  - On i_mem_ack: latch i_mem_rdata (forced to 0 for writes), o_err=0, go to RESP.
  - If the counter reaches TIMEOUT first: drop o_mem_req, rdata=0, o_err=1, go to RESP.
- RESP:
  - Pulse the owner's ack for exactly one cycle, together with o_err; rdata is on the owner's port.
  - No arbitration in this cycle; go to IDLE.
- Requesters sample their ack in RESP and may drop the request, or present a new one, from the next cycle.
- i_mem_ack in IDLE or RESP (stray or late after abort) is ignored: no state change, no ack.
- Command changes while a request is held are not sampled; the command is latched once, in IDLE.
- Reset (any time, including mid-BUSY):
  - State → IDLE; o_mem_req, acks and o_err → 0 immediately; streak and timeout counters → 0.
  - The in-flight transaction is abandoned with no ack.
- Reset values: every output 0.

## Timing
- Request high in IDLE at cycle N → o_mem_req high from N+1.
- i_mem_ack at cycle M → owner ack, rdata and o_err at M+1 (RESP) → IDLE at M+2.
- Minimum round trip, with memory acking in the first BUSY cycle: request at N, ack at N+2. Back-to-back throughput is one transaction per 3 cycles.
- Timeout: o_mem_req high for exactly TIMEOUT cycles, then ack with o_err=1 in the following cycle.
- Ack, rdata and o_err are registered; no combinational path from any input to any output.

## Test plan
- Single fetch: i_if_req, addr 0x100; memory acks 2 cycles after o_mem_req with 0x00500093 → o_mem_req from N+1, o_if_ack with rdata 0x00500093 and o_err=0; o_dm_ack stays 0.
- Data write: we=1, be=4'b0011, addr 0x204, wdata 0xDEADBEEF → o_mem_* carry exactly these values; o_dm_ack with rdata 0.
- Starvation bound: both ports requesting continuously, DM_STREAK_MAX=4 → grant order DM,DM,DM,DM,IF repeating; each transaction ≥3 cycles.
- Timeout: memory never acks, TIMEOUT=8 → o_mem_req high for 8 cycles, then o_dm_ack with o_err=1 and rdata 0. A late i_mem_ack afterwards produces no ack.
- Reset mid-BUSY: i_rst pulsed while o_mem_req=1 → all outputs 0 in the same cycle. After release, a new fetch completes normally and the streak has restarted at 0.
- Stray ack: i_mem_ack pulsed in IDLE → no ack pulse and no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-to-one fetch/data arbiter in front of a single-port unified memory
// Data port has priority, bounded by a streak limit while a fetch waits; BUSY aborts after TIMEOUT cycles.
module mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DM_STREAK_MAX = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_ack,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [DATA_W/8-1:0] i_dm_be,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  output logic                o_dm_ack,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_err,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata
);
  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(DM_STREAK_MAX + 1);
  localparam int TW   = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DM_STREAK_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              dm_wins;

  assign dm_wins = i_dm_req && (!i_if_req || (streak_q < STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (i_if_req || i_dm_req) begin
          state_d = BUSY;
          tmo_d   = '0;
          if (dm_wins) begin
            owner_d     = OWN_DM;
            mem_we_d    = i_dm_we;
            mem_be_d    = i_dm_be;
            mem_addr_d  = i_dm_addr;
            mem_wdata_d = i_dm_wdata;
            // Only grants that overtake a waiting fetch count toward the streak
            if (i_if_req && (streak_q != STREAK_MAX)) begin
              streak_d = streak_q + SW'(1);
            end
          end else begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = i_if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end
      BUSY: begin
        if (i_mem_ack) begin
          state_d = RESP;
          rdata_d = mem_we_q ? '0 : i_mem_rdata;
          err_d   = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Every output decodes registered state only
  assign o_mem_req   = (state_q == BUSY);
  assign o_mem_we    = mem_we_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
  assign o_dm_ack    = (state_q == RESP) && (owner_q == OWN_DM);
  assign o_err       = (state_q == RESP) && err_q;
  assign o_if_rdata  = o_if_ack ? rdata_q : '0;
  assign o_dm_rdata  = o_dm_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Directed vector table, streak/reset sequences, then random traffic against a cycle-arithmetic model.
module tb_mem_arbiter;
  localparam int STREAK = 4;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic        o_if_ack, o_dm_ack, o_err, o_mem_req, o_mem_we;
  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  int errors = 0;
  int checks = 0;
  int m_streak = 0;
  logic [31:0] mem_m [int];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DM_STREAK_MAX(STREAK), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_be(dm_be), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .o_dm_ack(o_dm_ack), .o_dm_rdata(o_dm_rdata), .o_err(o_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;        // BUSY cycle in which memory acks; 0 = never
    logic [31:0] mem_rdata;
    logic        x_we;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic [31:0] x_rdata;
    logic        x_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int k = int'(a[31:2]);
    return mem_m.exists(k) ? mem_m[k] : (a ^ 32'h5EED_0000);
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem_m[int'(a[31:2])] = w;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0; m_streak = 0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int n_req = 0;
    int t = 0;
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_be = v.be; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    chk("vec_req_rise", 32'(o_mem_req), 32'd1);
    chk("vec_cmd_we_be", 32'({o_mem_we, o_mem_be}), 32'({v.x_we, v.x_be}));
    chk("vec_cmd_addr", o_mem_addr, v.addr);
    chk("vec_cmd_wdata", o_mem_wdata, v.x_wdata);
    dm_addr = ~v.addr; dm_wdata = ~v.wdata; dm_we = ~v.we; if_addr = ~v.addr;
    while (o_mem_req && t < 4 * TMO) begin
      n_req++;
      chk("vec_cmd_hold", o_mem_addr, v.addr);
      chk("vec_busy_acks", 32'({o_if_ack, o_dm_ack, o_err}), 32'd0);
      if (v.lat == n_req) begin mem_ack = 1'b1; mem_rdata = v.mem_rdata; end
      @(negedge clk);
      t++;
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    chk("vec_req_cycles", 32'(n_req), 32'(v.lat == 0 ? TMO : v.lat));
    chk("vec_ack", 32'({o_if_ack, o_dm_ack, o_err}), 32'({!v.dm, v.dm, v.x_err}));
    chk("vec_rdata", v.dm ? o_dm_rdata : o_if_rdata, v.x_rdata);
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    chk("vec_late_ack", 32'({o_mem_req, o_if_ack, o_dm_ack, o_err}), 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("vec_stray_idle", 32'({o_mem_req, o_if_ack, o_dm_ack, o_err}), 32'd0);
  endtask

  // Both ports request continuously; memory acks in the first BUSY cycle.
  // Returns with the n-th grant in flight (not acked).
  task automatic stream_grants(input int n);
    int got = 0;
    int t = 0;
    int last_g = 0;
    logic prev_req = 1'b0;
    logic exp_dm;
    if_req = 1'b1; if_addr = 32'h1000;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h2000;
    while (got < n && t < 50 * n) begin
      @(negedge clk);
      t++;
      mem_ack = 1'b0;
      if (o_if_ack) if_addr = if_addr + 32'd4;
      if (o_dm_ack) dm_addr = dm_addr + 32'd4;
      if (o_mem_req && !prev_req) begin
        exp_dm = (m_streak < STREAK);
        if (exp_dm) m_streak++; else m_streak = 0;
        chk("grant_owner_dm", 32'(o_mem_addr[13]), 32'(exp_dm));
        if (got > 0) chk("grant_spacing", 32'(t - last_g), 32'd3);
        last_g = t;
        got++;
        if (got < n) begin mem_ack = 1'b1; mem_rdata = $urandom; end
      end
      prev_req = o_mem_req;
    end
    chk("grant_count", 32'(got), 32'(n));
  endtask

  task automatic random_run(input int ncyc);
    bit          active = 0, if_pend = 0, dm_pend = 0, own_dm = 0, t_we = 0, t_err = 0;
    bit          exp_req, exp_ack;
    logic [3:0]  t_be = '0;
    logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
    int          c = 0, free_at = 0, st = 0, d = 0, lat = 0;
    if_req = 1'b0; dm_req = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      c++;
      mem_ack = 1'b0;
      exp_req = active && c >= st && c < st + d;
      exp_ack = active && c == st + d;
      chk("rnd_mem_req", 32'(o_mem_req), 32'(exp_req));
      chk("rnd_acks", 32'({o_if_ack, o_dm_ack, o_err}),
          exp_ack ? 32'({!own_dm, own_dm, t_err}) : 32'd0);
      if (active && c == st) begin
        chk("rnd_cmd_we_be", 32'({o_mem_we, o_mem_be}), 32'({t_we, t_be}));
        chk("rnd_cmd_addr", o_mem_addr, t_addr);
        chk("rnd_cmd_wdata", o_mem_wdata, t_wdata);
      end
      if (exp_ack) begin
        chk("rnd_rdata", own_dm ? o_dm_rdata : o_if_rdata, t_rdata);
        if (t_we && !t_err) mem_wr(t_addr, t_be, t_wdata);
        if (own_dm) dm_pend = 0; else if_pend = 0;
        active = 0;
        free_at = c + 1;
      end
      if (exp_req && lat <= TMO && c == st + lat - 1) begin
        mem_ack = 1'b1;
        mem_rdata = t_we ? $urandom : mem_rd(t_addr);
      end else if (!exp_req && $urandom_range(0, 5) == 0) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
      end
      if (active && own_dm) begin
        dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom); dm_be = 4'($urandom);
      end
      if (active && !own_dm) if_addr = $urandom;
      if (!if_pend && $urandom_range(0, 2) == 0) begin if_pend = 1; if_addr = rnd_addr(); end
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend = 1; dm_we = 1'($urandom); dm_be = 4'($urandom);
        dm_addr = rnd_addr(); dm_wdata = $urandom;
      end
      if_req = if_pend;
      dm_req = dm_pend;
      if (!active && c >= free_at && (if_pend || dm_pend)) begin
        own_dm = dm_pend && (!if_pend || m_streak < STREAK);
        if (!own_dm) m_streak = 0;
        else if (if_pend && m_streak < STREAK) m_streak++;
        t_we    = own_dm ? dm_we : 1'b0;
        t_be    = own_dm ? dm_be : 4'hF;
        t_addr  = own_dm ? dm_addr : if_addr;
        t_wdata = own_dm ? dm_wdata : 32'd0;
        lat     = $urandom_range(1, TMO + 2);
        d       = (lat > TMO) ? TMO : lat;
        t_err   = (lat > TMO);
        t_rdata = (t_we || t_err) ? 32'd0 : mem_rd(t_addr);
        st      = c + 1;
        active  = 1;
      end
    end
  endtask

  initial begin
    vecs[0] = '{dm:1'b0, we:1'b0, be:4'h0, addr:32'h100, wdata:32'h0, lat:2, mem_rdata:32'h00500093,
                x_we:1'b0, x_be:4'hF, x_wdata:32'h0, x_rdata:32'h00500093, x_err:1'b0};
    vecs[1] = '{dm:1'b1, we:1'b1, be:4'b0011, addr:32'h204, wdata:32'hDEADBEEF, lat:1, mem_rdata:32'h12345678,
                x_we:1'b1, x_be:4'b0011, x_wdata:32'hDEADBEEF, x_rdata:32'h0, x_err:1'b0};
    vecs[2] = '{dm:1'b1, we:1'b0, be:4'hF, addr:32'h300, wdata:32'h0, lat:3, mem_rdata:32'hCAFEF00D,
                x_we:1'b0, x_be:4'hF, x_wdata:32'h0, x_rdata:32'hCAFEF00D, x_err:1'b0};
    vecs[3] = '{dm:1'b1, we:1'b0, be:4'hF, addr:32'h400, wdata:32'h0, lat:0, mem_rdata:32'h0,
                x_we:1'b0, x_be:4'hF, x_wdata:32'h0, x_rdata:32'h0, x_err:1'b1};
    vecs[4] = '{dm:1'b0, we:1'b0, be:4'h0, addr:32'h500, wdata:32'h0, lat:TMO, mem_rdata:32'h11112222,
                x_we:1'b0, x_be:4'hF, x_wdata:32'h0, x_rdata:32'h11112222, x_err:1'b0};
    vecs[5] = '{dm:1'b0, we:1'b0, be:4'h0, addr:32'h600, wdata:32'h0, lat:1, mem_rdata:32'hABCD0001,
                x_we:1'b0, x_be:4'hF, x_wdata:32'h0, x_rdata:32'hABCD0001, x_err:1'b0};

    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; mem_ack = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'({o_mem_req, o_if_ack, o_dm_ack, o_err, o_mem_we, o_mem_be}), 32'd0);
    chk("reset_addr", o_mem_addr, 32'd0);
    chk("reset_wdata", o_mem_wdata, 32'd0);
    chk("reset_rdata", o_if_rdata | o_dm_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    do_reset();
    stream_grants(7);
    chk("pre_reset_busy", 32'(o_mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midbusy_rst_ctrl", 32'({o_mem_req, o_if_ack, o_dm_ack, o_err, o_mem_we, o_mem_be}), 32'd0);
    chk("midbusy_rst_addr", o_mem_addr, 32'd0);
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; m_streak = 0;
    @(negedge clk);
    run_vec(vecs[5]);
    stream_grants(5);
    do_reset();

    random_run(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
